fpga_data_sequencer: RTL

Sequencer for the 4 x 128-bit dual-port AES data RAM. It owns the FPGA-side port (port 2) of that RAM and polls the command word the HPS writes. On a start command it fetches key and input block, runs the AES core through a start/done handshake, writes the result back, and posts status. The HPS side sees a mailbox: write key, data and command, then poll status or take the interrupt.

---
 rtl/fpga_data_sequencer_if.sv | 30 +++
 rtl/fpga_data_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fpga_data_sequencer_if.sv
// RAM port-2 and AES core signals of the data sequencer, bundled for the sequencer (master)
// and the RAM/core side (slave).
interface fpga_data_sequencer_if;
   logic [1:0]   ram_address;
   logic         ram_chipselect;
   logic         ram_write;
   logic [15:0]  ram_byteenable;
   logic [127:0] ram_writedata;
   logic [127:0] ram_readdata;
   logic         ram_clken;
   logic         aes_start;
   logic         aes_decrypt;
   logic [127:0] aes_key;
   logic [127:0] aes_din;
   logic         aes_done;
   logic [127:0] aes_dout;
   logic         done_irq;

   modport master (
      output ram_address, ram_chipselect, ram_write, ram_byteenable, ram_writedata, ram_clken,
      output aes_start, aes_decrypt, aes_key, aes_din, done_irq,
      input  ram_readdata, aes_done, aes_dout
   );

   modport slave (
      input  ram_address, ram_chipselect, ram_write, ram_byteenable, ram_writedata, ram_clken,
      input  aes_start, aes_decrypt, aes_key, aes_din, done_irq,
      output ram_readdata, aes_done, aes_dout
   );
endinterface

// File: rtl/fpga_data_sequencer.sv
// Polls the AES mailbox word, fetches key/data, runs the core and posts result and status.
// Optional AES watchdog: define FPGA_DATA_SEQ_TIMEOUT_EN.
module fpga_data_sequencer #(
   parameter int unsigned POLL_INTERVAL  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   fpga_data_sequencer_if.master bus
);

   localparam int unsigned PW = (POLL_INTERVAL > 0) ? $clog2(POLL_INTERVAL + 1) : 1;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_POLL_RD  = 4'd1;
   localparam logic [3:0] S_POLL_CHK = 4'd2;
   localparam logic [3:0] S_KEY_RD   = 4'd3;
   localparam logic [3:0] S_KEY_CAP  = 4'd4;
   localparam logic [3:0] S_DIN_CAP  = 4'd5;
   localparam logic [3:0] S_START    = 4'd6;
   localparam logic [3:0] S_WAIT     = 4'd7;
   localparam logic [3:0] S_WR_OUT   = 4'd8;
   localparam logic [3:0] S_WR_STAT  = 4'd9;

   logic [3:0]    state_q, state_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [127:0]  key_d, din_d, wdata_d;
   logic          dec_d, error_c;
   logic [1:0]    addr_d;
   logic          cs_d, wr_d, start_d, irq_d;
   logic [15:0]   be_d;

`ifdef FPGA_DATA_SEQ_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   // The RAM clock enable simply follows reset release.
   assign bus.ram_clken = ~reset;

   // State, counters and all outputs; outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= S_IDLE;
         poll_q             <= '0;
         bus.ram_address    <= '0;
         bus.ram_chipselect <= 1'b0;
         bus.ram_write      <= 1'b0;
         bus.ram_byteenable <= '0;
         bus.ram_writedata  <= '0;
         bus.aes_start      <= 1'b0;
         bus.aes_decrypt    <= 1'b0;
         bus.aes_key        <= '0;
         bus.aes_din        <= '0;
         bus.done_irq       <= 1'b0;
`ifdef FPGA_DATA_SEQ_TIMEOUT_EN
         tmo_q              <= '0;
`endif
      end else begin
         state_q            <= state_d;
         poll_q             <= poll_d;
         bus.ram_address    <= addr_d;
         bus.ram_chipselect <= cs_d;
         bus.ram_write      <= wr_d;
         bus.ram_byteenable <= be_d;
         bus.ram_writedata  <= wdata_d;
         bus.aes_start      <= start_d;
         bus.aes_decrypt    <= dec_d;
         bus.aes_key        <= key_d;
         bus.aes_din        <= din_d;
         bus.done_irq       <= irq_d;
`ifdef FPGA_DATA_SEQ_TIMEOUT_EN
         tmo_q              <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      poll_d  = '0;
      key_d   = bus.aes_key;
      din_d   = bus.aes_din;
      dec_d   = bus.aes_decrypt;
      wdata_d = '0;
      error_c = 1'b0;
      addr_d  = 2'd0;
      cs_d    = 1'b0;
      wr_d    = 1'b0;
      be_d    = 16'h0000;
      start_d = 1'b0;
      irq_d   = 1'b0;
`ifdef FPGA_DATA_SEQ_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (poll_q == PW'(POLL_INTERVAL)) state_d = S_POLL_RD;
            else                              poll_d  = poll_q + PW'(1);
         end
         S_POLL_RD:  state_d = S_POLL_CHK;
         S_POLL_CHK: begin
            if (bus.ram_readdata[0]) begin
               dec_d   = bus.ram_readdata[1];
               state_d = S_KEY_RD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_KEY_RD:   state_d = S_KEY_CAP;
         S_KEY_CAP: begin
            key_d   = bus.ram_readdata;
            state_d = S_DIN_CAP;
         end
         S_DIN_CAP: begin
            din_d   = bus.ram_readdata;
            state_d = S_START;
         end
         S_START: begin
`ifdef FPGA_DATA_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Completion takes priority over a watchdog expiry in the same cycle.
            if (bus.aes_done) begin
               wdata_d = bus.aes_dout;
               state_d = S_WR_OUT;
            end
`ifdef FPGA_DATA_SEQ_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
               error_c = 1'b1;
               state_d = S_WR_STAT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         S_WR_OUT:  state_d = S_WR_STAT;
         S_WR_STAT: begin
            dec_d   = 1'b0;
            state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase

      // Status byte1 = {5'b0, decrypt, error, done}; byte0 written as zero to clear START.
      if (state_d == S_WR_STAT) wdata_d[15:8] = {5'b0, bus.aes_decrypt, error_c, 1'b1};

      case (state_d)
         S_POLL_RD: begin addr_d = 2'd3; cs_d = 1'b1; end
         S_KEY_RD:  begin addr_d = 2'd0; cs_d = 1'b1; end
         S_KEY_CAP: begin addr_d = 2'd1; cs_d = 1'b1; end
         S_START:   start_d = 1'b1;
         S_WR_OUT: begin
            addr_d = 2'd2; cs_d = 1'b1; wr_d = 1'b1; be_d = 16'hFFFF;
         end
         S_WR_STAT: begin
            addr_d = 2'd3; cs_d = 1'b1; wr_d = 1'b1; be_d = 16'h0003; irq_d = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
